// File: rtl/tea_iter_engine.sv
// tea_iter_engine: iterative TEA encrypt/decrypt engine, one full TEA cycle
// (two Feistel half-rounds) per clock, valid/ready on both sides.
// Optional feature: define TEA_ABORT_EN to add an abort input that cancels
// a block in RUN or DONE and returns the engine to IDLE without a result.
module tea_iter_engine #(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_decrypt,
  input  logic [63:0]  in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         busy
`ifdef TEA_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Decrypt starts from the sum the encrypt schedule ends on.
  localparam logic [63:0] SUM_FULL = 64'(DELTA) * 64'(ROUNDS);
  localparam logic [31:0] SUM_DEC  = SUM_FULL[31:0];
  localparam logic [5:0]  LAST_CNT = 6'(ROUNDS - 1);

  state_t       state_q, state_d;
  logic [31:0]  v0_q, v0_d, v1_q, v1_d;
  logic [127:0] key_q, key_d;
  logic         dec_q, dec_d;
  logic [31:0]  sum_q, sum_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [63:0]  out_q, out_d;
  logic         abort_w;

  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  v0_r, v1_r, sum_r, s_enc;

`ifdef TEA_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] ka,
                                        input logic [31:0] kb, input logic [31:0] s);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

  // One TEA cycle on the latched operands; direction chosen by the latched mode.
  always_comb begin
    s_enc = sum_q + DELTA;
    v0_r  = v0_q;
    v1_r  = v1_q;
    sum_r = sum_q;
    if (!dec_q) begin
      v0_r  = v0_q + tea_f(v1_q, k0, k1, s_enc);
      v1_r  = v1_q + tea_f(v0_r, k2, k3, s_enc);
      sum_r = s_enc;
    end else begin
      v1_r  = v1_q - tea_f(v0_q, k2, k3, sum_q);
      v0_r  = v0_q - tea_f(v1_r, k0, k1, sum_q);
      sum_r = sum_q - DELTA;
    end
  end

  // Next-state logic: accept in IDLE, iterate in RUN, hold result in DONE.
  always_comb begin
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    key_d   = key_q;
    dec_d   = dec_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          v0_d    = in_data[63:32];
          v1_d    = in_data[31:0];
          key_d   = in_key;
          dec_d   = in_decrypt;
          sum_d   = in_decrypt ? SUM_DEC : 32'h0;
          cnt_d   = 6'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_w) begin
          state_d = IDLE;
        end else begin
          v0_d  = v0_r;
          v1_d  = v1_r;
          sum_d = sum_r;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_CNT) begin
            out_d   = {v0_r, v1_r};
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Abort wins over a simultaneous consumer handshake.
        if (abort_w || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v0_q    <= 32'h0;
      v1_q    <= 32'h0;
      key_q   <= 128'h0;
      dec_q   <= 1'b0;
      sum_q   <= 32'h0;
      cnt_q   <= 6'd0;
      out_q   <= 64'h0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Ready is gated by reset so it reads low while reset is held.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_tea_iter_engine.sv
// Scoreboard bench for tea_iter_engine: accepted requests push the reference
// result; an output monitor pops and compares on every output handshake.
module tb_tea_iter_engine;
  localparam int          ROUNDS = 32;
  localparam logic [31:0] DELTA  = 32'h9E3779B9;
  localparam logic [63:0] ENC_ZERO = 64'h41EA3A0A94BAA940;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_decrypt = 1'b0;
  logic [63:0]  in_data = 64'h0;
  logic [127:0] in_key = 128'h0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, busy;
  logic [63:0]  out_data;
`ifdef TEA_ABORT_EN
  logic         abort = 1'b0;
`endif

  tea_iter_engine dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
    .in_data(in_data), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
`ifdef TEA_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [63:0] data;
    int          acc;
  } exp_t;
  exp_t q[$];
  exp_t in_e, out_e;

  int passed = 0;
  int total = 0;
  int accepts = 0;
  logic [63:0] last_result = 64'h0;
  logic prev_v = 1'b0;

  // Reference TEA, written as the textbook loop over whole blocks.
  function automatic logic [63:0] tea_ref(input logic dec, input logic [63:0] d,
                                          input logic [127:0] k);
    logic [31:0] v0, v1, sum, a, b, c, e;
    v0 = d[63:32];
    v1 = d[31:0];
    a = k[127:96]; b = k[95:64]; c = k[63:32]; e = k[31:0];
    sum = 32'h0;
    if (dec) for (int i = 0; i < ROUNDS; i++) sum = sum + DELTA;
    for (int i = 0; i < ROUNDS; i++) begin
      if (!dec) begin
        sum = sum + DELTA;
        v0 = v0 + ((((v1 << 4) + a) ^ (v1 + sum) ^ ((v1 >> 5) + b)));
        v1 = v1 + ((((v0 << 4) + c) ^ (v0 + sum) ^ ((v0 >> 5) + e)));
      end else begin
        v1 = v1 - ((((v0 << 4) + c) ^ (v0 + sum) ^ ((v0 >> 5) + e)));
        v0 = v0 - ((((v1 << 4) + a) ^ (v1 + sum) ^ ((v1 >> 5) + b)));
        sum = sum - DELTA;
      end
    end
    return {v0, v1};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp_v);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp_v);
  endtask

  // Request-side monitor: every accepted block pushes its reference result.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      in_e.data = tea_ref(in_decrypt, in_data, in_key);
      in_e.acc  = cyc + 1;
      q.push_back(in_e);
      accepts++;
    end
  end

  // Result-side monitor: latency on the rising valid, data on handshake.
  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (q.size() == 0) chk1("unexpected_valid", 1'b1, 1'b0);
      else chk("latency", 64'(cyc - q[0].acc), 64'(ROUNDS));
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk1("unexpected_output", 1'b1, 1'b0);
      else begin
        out_e = q.pop_front();
        chk("result", out_data, out_e.data);
      end
    end
    prev_v = out_valid;
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic dec, input logic [63:0] d, input logic [127:0] k);
    int n;
    in_valid = 1'b1; in_decrypt = dec; in_data = d; in_key = k;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (!in_ready) chk1("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(out_valid && out_ready) && n < 400);
    if (!(out_valid && out_ready)) chk1("result_timeout", 1'b0, 1'b1);
    else last_result = out_data;
    @(posedge clk); #1;
  endtask

  logic [127:0] kk, kfix;
  logic [63:0]  dd, cc, ee;
  int           a0, nn;
  logic         vseen;

  initial begin
    kfix = 128'h12121212343434345656565678787878;
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("idle_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Known zero vector and its inverse.
    send(1'b0, 64'h0, 128'h0); wait_result();
    chk("enc_zero", last_result, ENC_ZERO);
    send(1'b1, ENC_ZERO, 128'h0); wait_result();
    chk("dec_zero", last_result, 64'h0);

    // Round trips under the fixed key.
    for (int i = 0; i < 4; i++) begin
      dd = {$urandom, $urandom};
      send(1'b0, dd, kfix); wait_result();
      cc = last_result;
      send(1'b1, cc, kfix); wait_result();
      chk("roundtrip", last_result, dd);
    end

    // Random mixed traffic, checked by the scoreboard.
    for (int i = 0; i < 6; i++) begin
      kk = {$urandom, $urandom, $urandom, $urandom};
      send(1'($urandom), {$urandom, $urandom}, kk); wait_result();
    end

    // Back-pressure: result must hold while out_ready is low.
    dd = {$urandom, $urandom};
    ee = tea_ref(1'b0, dd, kfix);
    out_ready = 1'b0;
    send(1'b0, dd, kfix);
    nn = 0;
    do begin @(negedge clk); nn++; end while (!out_valid && nn < 100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_data", out_data, ee);
      chk1("bp_valid", out_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("bp_release_valid", out_valid, 1'b0);
    chk1("bp_release_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Inputs churn during RUN/DONE; the result must not change.
    dd = {$urandom, $urandom};
    kk = {$urandom, $urandom, $urandom, $urandom};
    ee = tea_ref(1'b0, dd, kk);
    a0 = accepts;
    send(1'b0, dd, kk);
    nn = 0;
    forever begin
      in_valid = 1'b1;
      in_decrypt = 1'($urandom);
      in_data = {$urandom, $urandom};
      in_key = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk); nn++;
      if (out_valid || nn > 100) break;
      @(posedge clk); #1;
    end
    chk("interf_result", out_data, ee);
    @(posedge clk); #1 in_valid = 1'b0;
    chk("interf_accepts", 64'(accepts - a0), 64'd1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN.
    send(1'b0, {$urandom, $urandom}, kfix);
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk1("midrst_in_ready", in_ready, 1'b0);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk("midrst_out_data", out_data, 64'h0);
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    send(1'b0, 64'h0, 128'h0); wait_result();
    chk("post_rst_enc", last_result, ENC_ZERO);

`ifdef TEA_ABORT_EN
    // Abort at round 5: no result, engine idle on the next clock.
    send(1'b0, {$urandom, $urandom}, kfix);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    q.delete();
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    vseen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) vseen = 1'b1;
    end
    chk1("abort_no_valid", vseen, 1'b0);
    @(posedge clk); #1;
    send(1'b0, 64'h0, 128'h0); wait_result();
    chk("post_abort_enc", last_result, ENC_ZERO);
`else
    vseen = 1'b0;
`endif

    if (q.size() != 0) chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
